// File: rtl/uart_rx_par_pkg.sv
// Shared UART definitions: receiver state encoding, link data width and the
// even-parity helper that the transmitter also uses.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity bit: XOR of all data bits.
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_par_if.sv
// Receiver-side signal bundle: serial line in, received byte and status out.
// master = the receiver, slave = whoever drives rx and consumes the byte.
interface uart_rx_par_if #(
    parameter int DATA_W = 8
);
    logic              rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              par_err;
    logic              frame_err;
    logic              rx_busy;

    modport master (
        input  rx,
        output rx_data, rx_valid, par_err, frame_err, rx_busy
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, par_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line. Resets to 1 (line idle)
// so a reset never manufactures a falling edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s
);
    logic rx_meta;

    // Double-register the line into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end
endmodule

// File: rtl/uart_rx_par.sv
// UART receiver, LSB first, one stop bit, sampled at mid-bit.
// Build option UART_RX_PARITY_EN: when defined the frame carries an even
// parity bit after the data (8E1) and par_err reports a mismatch; when
// undefined the frame is 8N1 and par_err is tied low.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to mid start bit; line high there means a glitch
// DATA   | sampling one data bit every CLKS_PER_BIT cycles
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling the stop bit, then frame completes
module uart_rx_par #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_par_if.master bus
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              rx_s, rx_s_q;
    logic              fall, cnt_tc, half_tc;

    logic              cnt_clr, idx_clr, shift_en, done, busy;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q, frame_err_q;

`ifdef UART_RX_PARITY_EN
    logic              par_en;
    logic              par_bit_q;
    logic              par_err_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.rx),
        .rx_s  (rx_s)
    );

    assign fall    = rx_s_q & ~rx_s;
    assign cnt_tc  = (cnt_q == CNT_LAST);
    assign half_tc = (cnt_q == CNT_HALF);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; a line held low cannot restart a frame because IDLE
    // only leaves on an actual falling edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (fall) state_d = START;
            START:  if (half_tc) state_d = rx_s ? IDLE : DATA;
            DATA:   if (cnt_tc && (idx_q == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_tc) state_d = STOP;
`endif
            STOP:   if (cnt_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state strobes for the counters and sample registers.
    always_comb begin
        cnt_clr  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE:   cnt_clr = fall;
            START:  if (half_tc) begin
                        cnt_clr = 1'b1;
                        idx_clr = 1'b1;
                    end
            DATA:   if (cnt_tc) begin
                        cnt_clr  = 1'b1;
                        shift_en = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        par_en  = 1'b1;
                    end
`endif
            STOP:   if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        done    = 1'b1;
                    end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Previous synchronised level for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_s_q <= 1'b1;
        else        rx_s_q <= rx_s;
    end

    // Bit-period counter and data bit index; both only return to 0 by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            if (cnt_clr)                cnt_q <= '0;
            else if (state_q != IDLE)   cnt_q <= cnt_q + 1'b1;
            if (idx_clr)                idx_q <= '0;
            else if (shift_en && (idx_q != IDX_LAST)) idx_q <= idx_q + 1'b1;
        end
    end

    // Mid-bit data capture, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shift_q <= '0;
        else if (shift_en) shift_q[idx_q] <= rx_s;
    end

`ifdef UART_RX_PARITY_EN
    // Parity capture and mismatch flag, updated together with rx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (par_en) par_bit_q <= rx_s;
            if (done)   par_err_q <= par_bit_q ^ parity_of(shift_q);
        end
    end
    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    // Frame completion: byte and stop-bit status appear with the valid pulse
    // and hold until the next completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q <= done;
            if (done) begin
                rx_data_q   <= shift_q;
                frame_err_q <= ~rx_s;
            end
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = busy;

endmodule
